// File: rtl/sync_fifo_fwft_pkg.sv
// Shared helpers for the single-clock FIFO family.
package sync_fifo_fwft_pkg;

  function automatic int f_clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) begin
      res = res + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft_sdp_ram.sv
// Simple dual-port storage with a registered, clearable read port.
module sync_fifo_fwft_sdp_ram #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 9,
  parameter int RAM_STYLE  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  srst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  if (RAM_STYLE != 0) begin : g_block
    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

    // storage write port
    always_ff @(posedge clk) begin
      if (wr_en) begin
        mem[wr_addr] <= wr_data;
      end
    end

    // registered read port, cleared by reset and flush
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data <= {DATA_WIDTH{1'b0}};
      end else if (srst) begin
        rd_data <= {DATA_WIDTH{1'b0}};
      end else if (rd_en) begin
        rd_data <= mem[rd_addr];
      end
    end
  end else begin : g_dist
    (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

    // storage write port
    always_ff @(posedge clk) begin
      if (wr_en) begin
        mem[wr_addr] <= wr_data;
      end
    end

    // registered read port, cleared by reset and flush
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data <= {DATA_WIDTH{1'b0}};
      end else if (srst) begin
        rd_data <= {DATA_WIDTH{1'b0}};
      end else if (rd_en) begin
        rd_data <= mem[rd_addr];
      end
    end
  end

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with FWFT/standard read mode, programmable thresholds,
// synchronous flush, sticky error flags and an exact occupancy count.
module sync_fifo_fwft
  import sync_fifo_fwft_pkg::*;
#(
  parameter int DATA_WIDTH        = 64,
  parameter int FIFO_DEPTH        = 512,
  parameter int FWFT_MODE         = 1,
  parameter int PROG_FULL_THRESH  = (1 << f_clog2(FIFO_DEPTH)) - 4,
  parameter int PROG_EMPTY_THRESH = 4,
  parameter int RAM_STYLE         = 1,
  localparam int C_REAL_DEPTH     = 1 << f_clog2(FIFO_DEPTH),
  localparam int C_CAP            = C_REAL_DEPTH + ((FWFT_MODE != 0) ? 2 : 0),
  localparam int C_CNT_BITS       = f_clog2(C_CAP + 1)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  FLUSH,
  input  logic                  WR_EN,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  RD_EN,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  RD_VALID,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  PROG_FULL,
  output logic                  PROG_EMPTY,
  output logic [C_CNT_BITS-1:0] CNT,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  localparam int AW = f_clog2(C_REAL_DEPTH);
  localparam logic [C_CNT_BITS-1:0] PF_TH = C_CNT_BITS'(PROG_FULL_THRESH);
  localparam logic [C_CNT_BITS-1:0] PE_TH = C_CNT_BITS'(PROG_EMPTY_THRESH);

  logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [C_CNT_BITS-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] out_q, out_d, cache_q, cache_d, ram_dout_s;
  logic                  out_vld_q, out_vld_d, cache_vld_q, cache_vld_d;
  logic                  ram_vld_q, ram_vld_d, rd_valid_q, rd_valid_d;
  logic                  full_q, full_d, empty_q, empty_d;
  logic                  pfull_q, pfull_d, pempty_q, pempty_d;
  logic                  ovf_q, ovf_d, udf_q, udf_d;
  logic                  wr_acc_s, rd_acc_s, ram_rd_s, ram_empty_s, keep_out_s;
  logic [1:0]            stg_s;

  sync_fifo_fwft_sdp_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(AW),
    .RAM_STYLE (RAM_STYLE)
  ) u_ram (
    .clk    (CLK),
    .rst_n  (RST_N),
    .srst   (FLUSH),
    .wr_en  (wr_acc_s),
    .wr_addr(wr_ptr_q[AW-1:0]),
    .wr_data(WR_DATA),
    .rd_en  (ram_rd_s),
    .rd_addr(rd_ptr_q[AW-1:0]),
    .rd_data(ram_dout_s)
  );

  // request qualification, pointers, count and flags
  always_comb begin
    wr_acc_s    = WR_EN & ~full_q & ~FLUSH;
    rd_acc_s    = RD_EN & ~empty_q & ~FLUSH;
    ram_empty_s = (wr_ptr_q == rd_ptr_q);
    stg_s       = {1'b0, out_vld_q} + {1'b0, cache_vld_q} + {1'b0, ram_vld_q};
    // in-flight RAM reads count as held so the two stages can never be overrun
    if (FWFT_MODE != 0) begin
      ram_rd_s = ~FLUSH & ~ram_empty_s & ((stg_s < 2'd2) | rd_acc_s);
    end else begin
      ram_rd_s = rd_acc_s;
    end
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_acc_s};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, ram_rd_s};
    cnt_d    = cnt_q + {{(C_CNT_BITS-1){1'b0}}, wr_acc_s} - {{(C_CNT_BITS-1){1'b0}}, rd_acc_s};
    ovf_d    = ovf_q | (WR_EN & full_q);
    udf_d    = udf_q | (RD_EN & empty_q);
    if (FLUSH) begin
      wr_ptr_d = {(AW+1){1'b0}};
      rd_ptr_d = {(AW+1){1'b0}};
      cnt_d    = {C_CNT_BITS{1'b0}};
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      ovf_d    = ovf_d;
    end
    full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    pfull_d  = (cnt_d >= PF_TH);
    pempty_d = (cnt_d <= PE_TH);
  end

  // output stage: compact {out, cache, RAM read data} after removing a popped word
  always_comb begin
    out_d       = out_q;
    out_vld_d   = out_vld_q;
    cache_d     = cache_q;
    cache_vld_d = cache_vld_q;
    ram_vld_d   = ram_rd_s & (FWFT_MODE != 0);
    keep_out_s  = out_vld_q & ~rd_acc_s;
    if (FWFT_MODE == 0 || FLUSH) begin
      out_d       = {DATA_WIDTH{1'b0}};
      out_vld_d   = 1'b0;
      cache_d     = {DATA_WIDTH{1'b0}};
      cache_vld_d = 1'b0;
      ram_vld_d   = 1'b0;
    end else if (keep_out_s) begin
      if (!cache_vld_q && ram_vld_q) begin
        cache_d     = ram_dout_s;
        cache_vld_d = 1'b1;
      end else begin
        cache_vld_d = cache_vld_q;
      end
    end else if (cache_vld_q) begin
      out_d       = cache_q;
      out_vld_d   = 1'b1;
      cache_d     = ram_dout_s;
      cache_vld_d = ram_vld_q;
    end else if (ram_vld_q) begin
      out_d       = ram_dout_s;
      out_vld_d   = 1'b1;
      cache_vld_d = 1'b0;
    end else begin
      out_vld_d   = 1'b0;
      cache_vld_d = 1'b0;
    end
    if (FWFT_MODE != 0) begin
      empty_d    = ~out_vld_d;
      rd_valid_d = out_vld_d;
    end else begin
      empty_d    = (cnt_d == {C_CNT_BITS{1'b0}});
      rd_valid_d = rd_acc_s;
    end
  end

  // state registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q    <= {(AW+1){1'b0}};
      rd_ptr_q    <= {(AW+1){1'b0}};
      cnt_q       <= {C_CNT_BITS{1'b0}};
      out_q       <= {DATA_WIDTH{1'b0}};
      cache_q     <= {DATA_WIDTH{1'b0}};
      out_vld_q   <= 1'b0;
      cache_vld_q <= 1'b0;
      ram_vld_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      pfull_q     <= 1'b0;
      pempty_q    <= 1'b1;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      cache_q     <= cache_d;
      out_vld_q   <= out_vld_d;
      cache_vld_q <= cache_vld_d;
      ram_vld_q   <= ram_vld_d;
      rd_valid_q  <= rd_valid_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      pfull_q     <= pfull_d;
      pempty_q    <= pempty_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
    end
  end

  assign RD_DATA    = (FWFT_MODE != 0) ? out_q : ram_dout_s;
  assign RD_VALID   = rd_valid_q;
  assign FULL       = full_q;
  assign EMPTY      = empty_q;
  assign PROG_FULL  = pfull_q;
  assign PROG_EMPTY = pempty_q;
  assign CNT        = cnt_q;
  assign OVERFLOW   = ovf_q;
  assign UNDERFLOW  = udf_q;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Directed bench: FWFT instance (depth 16, prog-full 14) plus a standard-mode instance.
module tb_sync_fifo_fwft;

  logic       clk = 1'b0;
  logic       f_rst_n, f_flush, f_wr, f_rd, f_vld, f_full, f_empty, f_pf, f_pe, f_ovf, f_udf;
  logic [7:0] f_wdata, f_rdata;
  logic [4:0] f_cnt;
  logic       s_rst_n, s_flush, s_wr, s_rd, s_vld, s_full, s_empty, s_pf, s_pe, s_ovf, s_udf;
  logic [7:0] s_wdata, s_rdata;
  logic [4:0] s_cnt;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  sync_fifo_fwft #(
    .DATA_WIDTH(8), .FIFO_DEPTH(16), .FWFT_MODE(1),
    .PROG_FULL_THRESH(14), .PROG_EMPTY_THRESH(4), .RAM_STYLE(1)
  ) u_fwft (
    .CLK(clk), .RST_N(f_rst_n), .FLUSH(f_flush), .WR_EN(f_wr), .WR_DATA(f_wdata),
    .RD_EN(f_rd), .RD_DATA(f_rdata), .RD_VALID(f_vld), .FULL(f_full), .EMPTY(f_empty),
    .PROG_FULL(f_pf), .PROG_EMPTY(f_pe), .CNT(f_cnt), .OVERFLOW(f_ovf), .UNDERFLOW(f_udf)
  );

  sync_fifo_fwft #(
    .DATA_WIDTH(8), .FIFO_DEPTH(16), .FWFT_MODE(0),
    .PROG_FULL_THRESH(12), .PROG_EMPTY_THRESH(4), .RAM_STYLE(0)
  ) u_std (
    .CLK(clk), .RST_N(s_rst_n), .FLUSH(s_flush), .WR_EN(s_wr), .WR_DATA(s_wdata),
    .RD_EN(s_rd), .RD_DATA(s_rdata), .RD_VALID(s_vld), .FULL(s_full), .EMPTY(s_empty),
    .PROG_FULL(s_pf), .PROG_EMPTY(s_pe), .CNT(s_cnt), .OVERFLOW(s_ovf), .UNDERFLOW(s_udf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    f_rst_n = 1'b0; f_flush = 1'b0; f_wr = 1'b0; f_rd = 1'b0; f_wdata = 8'h00;
    s_rst_n = 1'b0; s_flush = 1'b0; s_wr = 1'b0; s_rd = 1'b0; s_wdata = 8'h00;
    tick();
    tick();
    chk("rst_empty", f_empty, 1);
    chk("rst_pempty", f_pe, 1);
    chk("rst_full", f_full, 0);
    chk("rst_pfull", f_pf, 0);
    chk("rst_cnt", f_cnt, 0);
    chk("rst_rdata", f_rdata, 8'h00);
    chk("rst_rvalid", f_vld, 0);
    chk("rst_ovf", f_ovf, 0);
    chk("rst_udf", f_udf, 0);
    chk("std_rst_empty", s_empty, 1);
    f_rst_n = 1'b1;
    s_rst_n = 1'b1;
    tick();

    // 1: first-word latency
    f_wr = 1'b1; f_wdata = 8'hA5;
    tick();
    f_wr = 1'b0;
    chk("t1_cnt_c0", f_cnt, 1);
    chk("t1_empty_c0", f_empty, 1);
    tick();
    chk("t1_empty_c1", f_empty, 1);
    tick();
    chk("t1_empty_c2", f_empty, 0);
    chk("t1_rvalid_c2", f_vld, 1);
    chk("t1_rdata_c2", f_rdata, 8'hA5);
    chk("t1_cnt_c2", f_cnt, 1);
    chk("t1_pempty_c2", f_pe, 1);
    f_rd = 1'b1;
    tick();
    f_rd = 1'b0;
    chk("t1_pop_empty", f_empty, 1);
    chk("t1_pop_cnt", f_cnt, 0);

    // 2: fill to capacity 18, 19th write overflows
    for (int i = 1; i <= 19; i++) begin
      f_wr = 1'b1; f_wdata = 8'(i);
      tick();
      chk("t2_cnt", f_cnt, (i <= 18) ? i : 18);
      chk("t2_full", f_full, (i >= 18) ? 1 : 0);
      chk("t2_pfull", f_pf, (i >= 14) ? 1 : 0);
      chk("t2_ovf", f_ovf, (i >= 19) ? 1 : 0);
    end
    f_wr = 1'b0;
    // drain to 7 entries, verifying order
    for (int i = 1; i <= 11; i++) begin
      chk("t2_drain_data", f_rdata, i);
      f_rd = 1'b1;
      tick();
    end
    f_rd = 1'b0;
    chk("t2_drain_cnt", f_cnt, 7);
    chk("t2_drain_full", f_full, 0);
    chk("t2_drain_ovf_sticky", f_ovf, 1);

    // 5: flush wins over write, clears sticky flag
    f_flush = 1'b1; f_wr = 1'b1; f_wdata = 8'hEE;
    tick();
    f_flush = 1'b0; f_wr = 1'b0;
    chk("t5_cnt", f_cnt, 0);
    chk("t5_empty", f_empty, 1);
    chk("t5_ovf", f_ovf, 0);
    chk("t5_rvalid", f_vld, 0);
    chk("t5_rdata", f_rdata, 8'h00);
    chk("t5_pempty", f_pe, 1);
    tick(); tick(); tick();
    chk("t5_write_lost_empty", f_empty, 1);
    chk("t5_write_lost_cnt", f_cnt, 0);

    // 4: pop three entries back-to-back, fourth read underflows
    for (int i = 1; i <= 3; i++) begin
      f_wr = 1'b1; f_wdata = 8'(i);
      tick();
    end
    f_wr = 1'b0;
    tick(); tick(); tick();
    for (int j = 0; j < 4; j++) begin
      if (j < 3) begin
        chk("t4_pop_data", f_rdata, j + 1);
        chk("t4_pop_valid", f_vld, 1);
      end else begin
        chk("t4_empty_before_4th", f_empty, 1);
        chk("t4_udf_before_4th", f_udf, 0);
      end
      f_rd = 1'b1;
      tick();
    end
    f_rd = 1'b0;
    chk("t4_udf", f_udf, 1);
    chk("t4_cnt", f_cnt, 0);
    chk("t4_empty", f_empty, 1);
    f_flush = 1'b1;
    tick();
    f_flush = 1'b0;
    chk("t4_flush_udf", f_udf, 0);

    // 3: sustained simultaneous read+write, no bubbles
    for (int i = 1; i <= 5; i++) begin
      f_wr = 1'b1; f_wdata = 8'(i);
      tick();
    end
    f_wr = 1'b0;
    tick(); tick(); tick();
    for (int i = 0; i < 20; i++) begin
      chk("t3_stream_data", f_rdata, i + 1);
      chk("t3_stream_valid", f_vld, 1);
      f_wr = 1'b1; f_rd = 1'b1; f_wdata = 8'(i + 6);
      tick();
      chk("t3_stream_cnt", f_cnt, 5);
    end
    f_wr = 1'b0; f_rd = 1'b0;
    chk("t3_tail_data", f_rdata, 21);

    // 6: standard read mode
    s_wr = 1'b1; s_wdata = 8'h10;
    tick();
    chk("t6_empty_after_wr", s_empty, 0);
    chk("t6_cnt1", s_cnt, 1);
    s_wdata = 8'h11;
    tick();
    s_wr = 1'b0;
    chk("t6_rvalid_idle", s_vld, 0);
    s_rd = 1'b1;
    tick();
    s_rd = 1'b0;
    chk("t6_rvalid_k1", s_vld, 1);
    chk("t6_rdata_k1", s_rdata, 8'h10);
    chk("t6_cnt_k1", s_cnt, 1);
    tick();
    chk("t6_rvalid_k2", s_vld, 0);
    chk("t6_rdata_hold", s_rdata, 8'h10);
    s_rd = 1'b1; s_wr = 1'b1; s_wdata = 8'h12;
    tick();
    chk("t6_burst_data", s_rdata, 8'h11);
    chk("t6_burst_valid", s_vld, 1);
    #3;
    s_rst_n = 1'b0;
    #1;
    chk("t6_rst_cnt", s_cnt, 0);
    chk("t6_rst_empty", s_empty, 1);
    chk("t6_rst_rdata", s_rdata, 8'h00);
    chk("t6_rst_rvalid", s_vld, 0);
    chk("t6_rst_pempty", s_pe, 1);
    s_rd = 1'b0; s_wr = 1'b0;
    tick();
    s_rst_n = 1'b1;
    tick();
    chk("t6_post_rst_empty", s_empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
